// File: rtl/aabb_pkg.sv
// Shared AABB broadphase types: packed box struct, scan FSM states and the
// sign-magnitude fp32 ordering helper used by the overlap comparator.
package aabb_pkg;

    typedef struct packed {
        logic [31:0] minx;
        logic [31:0] maxx;
        logic [31:0] miny;
        logic [31:0] maxy;
        logic [31:0] minz;
        logic [31:0] maxz;
    } aabb_t;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

    localparam int F_MINX     = 0;
    localparam int F_MAXX     = 1;
    localparam int F_MINY     = 2;
    localparam int F_MAXY     = 3;
    localparam int F_MINZ     = 4;
    localparam int F_MAXZ     = 5;
    localparam int NUM_FIELDS = 6;

    // a <= b for non-NaN IEEE-754 singles; +0 and -0 compare equal.
    function automatic logic fp32_le(input logic [31:0] a, input logic [31:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        if (a_zero && b_zero) return 1'b1;
        case ({a[31], b[31]})
            2'b10:   return 1'b1;
            2'b01:   return 1'b0;
            2'b00:   return a[30:0] <= b[30:0];
            default: return a[30:0] >= b[30:0];
        endcase
    endfunction

endpackage

// File: rtl/aabb_pair_finder_if.sv
// Handshake bundle for aabb_pair_finder: AABB input stream, pair output stream
// and status flags. bad_aabb exists only when AABB_SANITY_EN is defined.
interface aabb_pair_finder_if #(
    parameter int ID_W = 3
);
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [31:0]     in_aabb0;
    logic [31:0]     in_aabb1;
    logic [31:0]     in_aabb2;
    logic [31:0]     in_aabb3;
    logic [31:0]     in_aabb4;
    logic [31:0]     in_aabb5;
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_id_a;
    logic [ID_W-1:0] out_id_b;
    logic            frame_done;
    logic            overflow;
`ifdef AABB_SANITY_EN
    logic            bad_aabb;

    modport master (
        output in_valid, in_last, in_aabb0, in_aabb1, in_aabb2, in_aabb3, in_aabb4, in_aabb5,
        output out_ready,
        input  in_ready, out_valid, out_id_a, out_id_b, frame_done, overflow, bad_aabb
    );
    modport slave (
        input  in_valid, in_last, in_aabb0, in_aabb1, in_aabb2, in_aabb3, in_aabb4, in_aabb5,
        input  out_ready,
        output in_ready, out_valid, out_id_a, out_id_b, frame_done, overflow, bad_aabb
    );
`else
    modport master (
        output in_valid, in_last, in_aabb0, in_aabb1, in_aabb2, in_aabb3, in_aabb4, in_aabb5,
        output out_ready,
        input  in_ready, out_valid, out_id_a, out_id_b, frame_done, overflow
    );
    modport slave (
        input  in_valid, in_last, in_aabb0, in_aabb1, in_aabb2, in_aabb3, in_aabb4, in_aabb5,
        input  out_ready,
        output in_ready, out_valid, out_id_a, out_id_b, frame_done, overflow
    );
`endif
endinterface

// File: rtl/aabb_overlap_cmp.sv
// Combinational AABB-vs-AABB overlap test; touching faces count as overlap.
import aabb_pkg::*;

module aabb_overlap_cmp (
    input  aabb_t a,
    input  aabb_t b,
    output logic  overlap
);
    assign overlap = fp32_le(a.minx, b.maxx) & fp32_le(b.minx, a.maxx)
                   & fp32_le(a.miny, b.maxy) & fp32_le(b.miny, a.maxy)
                   & fp32_le(a.minz, b.maxz) & fp32_le(b.minz, a.maxz);
endmodule

// File: rtl/aabb_pair_finder.sv
// Broadphase pair finder: stores each frame's AABBs in slots and tests every new
// box against all older ones, emitting overlapping (older, newer) id pairs.
// Optional AABB_SANITY_EN: discard inverted boxes and flag them on bad_aabb.
import aabb_pkg::*;

module aabb_pair_finder #(
    parameter int MAX_OBJS = 8,
    parameter int ID_W     = 3
) (
    input logic               clk,
    input logic               rst,
    aabb_pair_finder_if.slave bus
);
    localparam int CNT_W = ID_W + 1;

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0] k;
    logic            last_q;
    logic            drop_q;
    logic            run_q;
    logic            overflow_q;
    logic [ID_W-1:0] id_a_q;
    logic [ID_W-1:0] id_b_q;

    aabb_t           slots [MAX_OBJS];
    aabb_t           new_box;
    aabb_t           in_box;
    logic [31:0]     in_words [NUM_FIELDS];

    logic            accept;
    logic            full;
    logic            bad_box;
    logic            hit;
    logic            k_at_end;

    assign in_words[0] = bus.in_aabb0;
    assign in_words[1] = bus.in_aabb1;
    assign in_words[2] = bus.in_aabb2;
    assign in_words[3] = bus.in_aabb3;
    assign in_words[4] = bus.in_aabb4;
    assign in_words[5] = bus.in_aabb5;

    assign in_box = '{minx: in_words[F_MINX], maxx: in_words[F_MAXX],
                      miny: in_words[F_MINY], maxy: in_words[F_MAXY],
                      minz: in_words[F_MINZ], maxz: in_words[F_MAXZ]};

    assign accept   = bus.in_valid & bus.in_ready;
    assign full     = (count == CNT_W'(MAX_OBJS));
    assign k_at_end = ({1'b0, k} == count - CNT_W'(1));

`ifdef AABB_SANITY_EN
    logic bad_q;

    assign bad_box = ~(fp32_le(in_box.minx, in_box.maxx)
                     & fp32_le(in_box.miny, in_box.maxy)
                     & fp32_le(in_box.minz, in_box.maxz));
    assign bus.bad_aabb = bad_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_q <= 1'b0;
        end else if (state == IDLE && accept && bad_box) begin
            bad_q <= 1'b1;
        end
    end
`else
    assign bad_box = 1'b0;
`endif

    aabb_overlap_cmp u_cmp (
        .a       (new_box),
        .b       (slots[k]),
        .overlap (hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (full || bad_box || count == '0) ? FIN : SCAN;
            SCAN: begin
                if (hit)           state_nxt = EMIT;
                else if (k_at_end) state_nxt = FIN;
            end
            EMIT: if (bus.out_ready) state_nxt = k_at_end ? FIN : SCAN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; run_q keeps in_ready low until after reset.
    always_comb begin
        bus.in_ready   = run_q & (state == IDLE);
        bus.out_valid  = (state == EMIT);
        bus.frame_done = (state == FIN) & last_q;
    end

    assign bus.out_id_a = id_a_q;
    assign bus.out_id_b = id_b_q;
    assign bus.overflow = overflow_q;

    // Control registers: slot count, scan index, frame flags, pair ids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            count      <= '0;
            k          <= '0;
            last_q     <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
            id_a_q     <= '0;
            id_b_q     <= '0;
        end else begin
            run_q <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    last_q <= bus.in_last;
                    drop_q <= full | bad_box;
                    k      <= '0;
                    if (full) overflow_q <= 1'b1;
                end
                SCAN: begin
                    if (hit) begin
                        id_a_q <= k;
                        id_b_q <= count[ID_W-1:0];
                    end else if (!k_at_end) begin
                        k <= k + ID_W'(1);
                    end
                end
                EMIT: if (bus.out_ready && !k_at_end) k <= k + ID_W'(1);
                FIN: begin
                    if (last_q)       count <= '0;
                    else if (!drop_q) count <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Box storage is datapath only and is never cleared.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && !full && !bad_box) begin
            slots[count[ID_W-1:0]] <= in_box;
            new_box                <= in_box;
        end
    end

endmodule

// File: tb/tb_aabb_pair_finder.sv
// Directed, table-driven bench for aabb_pair_finder with hand-written
// sequences for reset behaviour, reset mid-EMIT and the sanity option.
module tb_aabb_pair_finder;
    localparam int ID_W = 3;

    localparam logic [31:0] Z   = 32'h0000_0000;
    localparam logic [31:0] NZ  = 32'h8000_0000;
    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;
    localparam logic [31:0] M1  = 32'hBF80_0000;

    typedef struct {
        logic [5:0][31:0] w;
        bit               last;
        int               stall;
        logic [7:0]       mask;
        bit               done;
        bit               ovf;
        bit               keep;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;
    rec_t tbl [$];

    aabb_pair_finder_if #(.ID_W(ID_W)) bus ();

    aabb_pair_finder #(.MAX_OBJS(8), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [5:0][31:0] cube(input logic [31:0] lo, input logic [31:0] hi);
        logic [5:0][31:0] w;
        for (int i = 0; i < 6; i += 2) begin
            w[i]   = lo;
            w[i+1] = hi;
        end
        return w;
    endfunction

    function automatic rec_t mkrec(input logic [5:0][31:0] w, input bit last, input int stall,
                                   input logic [7:0] mask, input bit done, input bit ovf,
                                   input bit keep);
        rec_t r;
        r.w = w; r.last = last; r.stall = stall; r.mask = mask;
        r.done = done; r.ovf = ovf; r.keep = keep;
        return r;
    endfunction

    task automatic drive_box(input logic [5:0][31:0] w, input bit last);
        bus.in_aabb0 = w[0]; bus.in_aabb1 = w[1]; bus.in_aabb2 = w[2];
        bus.in_aabb3 = w[3]; bus.in_aabb4 = w[4]; bus.in_aabb5 = w[5];
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    // Send one box, serve its pairs with the requested stall, then wait for IDLE.
    task automatic apply(input rec_t r);
        logic [7:0]      mask;
        logic [ID_W-1:0] ha;
        logic [ID_W-1:0] hb;
        bit              holding;
        bit              done_seen;
        bit              fin;
        int              st;
        int              n;
        mask = '0; holding = 0; done_seen = 0; fin = 0; st = 0; ha = '0; hb = '0;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", bus.in_ready, 1'b1);
        bus.out_ready = (r.stall == 0);
        drive_box(r.w, r.last);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (bus.frame_done) done_seen = 1;
            if (bus.out_valid) begin
                if (!holding) begin
                    holding = 1;
                    ha = bus.out_id_a;
                    hb = bus.out_id_b;
                    st = 0;
                    chk("id_b", hb, next_id);
                end else begin
                    chk("stall_id_a", bus.out_id_a, ha);
                    chk("stall_id_b", bus.out_id_b, hb);
                end
                if (st < r.stall) begin
                    bus.out_ready = 1'b0;
                    chk("stall_in_ready", bus.in_ready, 1'b0);
                    st++;
                end else begin
                    bus.out_ready = 1'b1;
                    mask |= 8'(1) << ha;
                    holding = 0;
                end
            end else if (bus.in_ready) begin
                fin = 1;
            end else begin
                bus.out_ready = (r.stall == 0);
            end
            if (!fin) @(negedge clk);
        end
        chk("settle", fin, 1'b1);
        chk("pair_mask", mask, r.mask);
        chk("frame_done", done_seen, r.done);
        chk("overflow", bus.overflow, r.ovf);
        if (r.last)      next_id = 0;
        else if (r.keep) next_id++;
    endtask

    initial begin
        logic [5:0][31:0] c01;
        logic [5:0][31:0] c12;
        logic [5:0][31:0] sph;
        logic [5:0][31:0] far;
        int               n;
        int               split;

        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        bus.in_aabb0 = '0; bus.in_aabb1 = '0; bus.in_aabb2 = '0;
        bus.in_aabb3 = '0; bus.in_aabb4 = '0; bus.in_aabb5 = '0;

        c01 = cube(Z, ONE);
        c12 = cube(ONE, TWO);
        sph = {32'h4000_0000, 32'h3F80_0000, 32'h3EEC_F11B, 32'hBF09_8772,
               32'hBE3B_20FB, 32'hBF97_641F};
        far = {32'h4144_F5C3, 32'h40C9_EB85, 32'h4089_EB85, 32'hBFD8_51EC,
               32'hC153_AE14, 32'hC199_D70A};

        // touching faces, then far-apart sphere/box
        tbl.push_back(mkrec(c01, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mkrec(c12, 1, 0, 8'h01, 1, 0, 1));
        tbl.push_back(mkrec(sph, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mkrec(far, 1, 0, 8'h00, 1, 0, 1));
        // backpressure: four identical boxes, five stall cycles per pair
        tbl.push_back(mkrec(c01, 0, 5, 8'h00, 0, 0, 1));
        tbl.push_back(mkrec(c01, 0, 5, 8'h01, 0, 0, 1));
        tbl.push_back(mkrec(c01, 0, 5, 8'h03, 0, 0, 1));
        tbl.push_back(mkrec(c01, 1, 5, 8'h07, 1, 0, 1));
        // signed zeros
        tbl.push_back(mkrec({ONE, NZ, ONE, NZ, ONE, NZ}, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mkrec({Z, M1, Z, M1, Z, M1}, 1, 0, 8'h01, 1, 0, 1));
        // full frame, then a discarded ninth box
        for (int i = 0; i < 8; i++)
            tbl.push_back(mkrec(c01, 0, 0, 8'((1 << i) - 1), 0, 0, 1));
        tbl.push_back(mkrec(c01, 1, 0, 8'h00, 1, 1, 0));
        split = tbl.size();
        // after reset: single-object frame, then a two-box frame from id 0
        tbl.push_back(mkrec(c12, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mkrec(c01, 0, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mkrec(c12, 1, 0, 8'h01, 1, 0, 1));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_id_a", bus.out_id_a, 0);
        chk("rst_id_b", bus.out_id_b, 0);
`ifdef AABB_SANITY_EN
        chk("rst_bad_aabb", bus.bad_aabb, 1'b0);
`endif
        rst = 1'b1;
        #1;
        chk("ready_at_release", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_release", bus.in_ready, 1'b1);

        for (int i = 0; i < split; i++) apply(tbl[i]);

        // reset while a pair is held in EMIT
        apply(mkrec(c01, 0, 0, 8'h00, 0, 1, 1));
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_box(c01, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("emit_reached", bus.out_valid, 1'b1);
        chk("emit_id_a", bus.out_id_a, 0);
        chk("emit_id_b", bus.out_id_b, 1);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        chk("abort_overflow", bus.overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        next_id = 0;
        @(negedge clk);
        chk("ready_after_abort", bus.in_ready, 1'b1);

        for (int i = split; i < tbl.size(); i++) apply(tbl[i]);

`ifdef AABB_SANITY_EN
        apply(mkrec(c01, 0, 0, 8'h00, 0, 0, 1));
        apply(mkrec({ONE, Z, ONE, Z, Z, ONE}, 0, 0, 8'h00, 0, 0, 0));
        chk("bad_aabb_set", bus.bad_aabb, 1'b1);
        apply(mkrec(c01, 1, 0, 8'h01, 1, 0, 1));
        chk("bad_aabb_sticky", bus.bad_aabb, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
